// File: rtl/beep_scheduler_if.sv
// Bundle between the four alarm requesters, the scheduler and the beeper tone generator.
// The scheduler takes the slave modport; the requester/beeper side takes the master modport.
interface beep_scheduler_if;
    logic [3:0]  req;
    logic [15:0] req_beeps;
    logic [15:0] req_duty;
    logic        beep_enable;
    logic [3:0]  duty_cycle;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;

    modport master (
        output req, req_beeps, req_duty,
        input  beep_enable, duty_cycle, grant, done, busy
    );

    modport slave (
        input  req, req_beeps, req_duty,
        output beep_enable, duty_cycle, grant, done, busy
    );
endinterface

// File: rtl/beep_scheduler.sv
// Arbitrates four alarm requesters onto one beeper and plays N on/off beeps at the winner's duty.
// Latency: grant/busy/beep_enable one edge after req is sampled in IDLE; done one cycle before next grant.
// No backpressure: requests are levels, held until done; BEEP_SCHED_RR_EN selects round-robin over fixed priority.
module beep_scheduler #(
    parameter int TICK_DIV  = 1000,
    parameter int ON_TICKS  = 100,
    parameter int OFF_TICKS = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    beep_scheduler_if.slave   bus
);
    localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PW   = $clog2(TICK_DIV);
    localparam int TW   = $clog2(MAXT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [TW-1:0] tick_cnt, tick_cnt_n;
    logic [3:0]    remain, remain_n;
    logic [3:0]    duty, duty_n;
    logic [3:0]    grant, grant_n;
    logic [3:0]    done, done_n;
    logic          beep_en, beep_en_n;
    logic          busy, busy_n;
    logic          any_req;
    logic [1:0]    win;
    logic [3:0]    sel_beeps, sel_duty;
    logic          tick;
`ifdef BEEP_SCHED_RR_EN
    logic [1:0]    ptr, ptr_n;
`endif

    // Winner selection; only consumed while IDLE.
    always_comb begin
        win     = 2'd0;
        any_req = 1'b0;
`ifdef BEEP_SCHED_RR_EN
        for (int i = 0; i < 4; i++) begin
            if (!any_req && bus.req[ptr + 2'(i)]) begin
                win     = ptr + 2'(i);
                any_req = 1'b1;
            end
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[i]) begin
                win     = 2'(i);
                any_req = 1'b1;
            end
        end
`endif
        sel_beeps = bus.req_beeps[{win, 2'b00} +: 4];
        sel_duty  = bus.req_duty[{win, 2'b00} +: 4];
    end

    always_comb begin
        tick       = (presc == PRESC_LAST);
        state_n    = state;
        presc_n    = tick ? '0 : presc + PW'(1);
        tick_cnt_n = tick_cnt;
        remain_n   = remain;
        duty_n     = duty;
        grant_n    = grant;
        done_n     = 4'd0;
`ifdef BEEP_SCHED_RR_EN
        ptr_n      = ptr;
`endif
        case (state)
            IDLE: begin
                presc_n = '0;
                if (any_req) begin
                    state_n    = ON;
                    tick_cnt_n = '0;
                    remain_n   = (sel_beeps == 4'd0) ? 4'd1 : sel_beeps;
                    duty_n     = sel_duty;
                    grant_n    = 4'b0001 << win;
`ifdef BEEP_SCHED_RR_EN
                    ptr_n      = win + 2'd1;
`endif
                end
            end
            ON: begin
                if (tick) begin
                    if (tick_cnt == ON_LAST) begin
                        tick_cnt_n = '0;
                        remain_n   = (remain != 4'd0) ? remain - 4'd1 : 4'd0;
                        state_n    = OFF;
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    if (tick_cnt == OFF_LAST) begin
                        tick_cnt_n = '0;
                        if (remain != 4'd0) begin
                            state_n = ON;
                        end else begin
                            state_n = IDLE;
                            done_n  = grant;
                            grant_n = 4'd0;
                            duty_n  = 4'd0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'd0;
                duty_n  = 4'd0;
            end
        endcase
        // Outputs are registered versions of what the next state implies.
        beep_en_n = (state_n == ON);
        busy_n    = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= '0;
            tick_cnt <= '0;
            remain   <= 4'd0;
            duty     <= 4'd0;
            grant    <= 4'd0;
            done     <= 4'd0;
            beep_en  <= 1'b0;
            busy     <= 1'b0;
`ifdef BEEP_SCHED_RR_EN
            ptr      <= 2'd0;
`endif
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            tick_cnt <= tick_cnt_n;
            remain   <= remain_n;
            duty     <= duty_n;
            grant    <= grant_n;
            done     <= done_n;
            beep_en  <= beep_en_n;
            busy     <= busy_n;
`ifdef BEEP_SCHED_RR_EN
            ptr      <= ptr_n;
`endif
        end
    end

    assign bus.beep_enable = beep_en;
    assign bus.duty_cycle  = duty;
    assign bus.grant       = grant;
    assign bus.done        = done;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench for beep_scheduler: stimulus pushes expected service records, a negedge monitor
// measures each service (length, beeps, on cycles, duty, gap) and compares when done pulses.
module tb_beep_scheduler;
    localparam int ON_CYC  = 12;
    localparam int OFF_CYC = 8;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    beep_scheduler_if bif ();

    beep_scheduler #(.TICK_DIV(4), .ON_TICKS(3), .OFF_TICKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        logic [3:0] done;
        logic [3:0] duty;
        int         beeps;
        int         len;
        int         on;
        int         gap;
    } exp_t;

    exp_t sbq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [3:0] du, input int n, input int gap);
        exp_t e;
        e.done = d; e.duty = du; e.beeps = n;
        e.len = n * (ON_CYC + OFF_CYC); e.on = n * ON_CYC; e.gap = gap;
        sbq.push_back(e);
    endtask

    // Monitor state for the service in progress.
    logic       in_svc = 1'b0;
    logic [3:0] svc_grant, svc_duty;
    int         len, on_cnt, rises, hi_run, lo_run, pat_bad, gap, done_cyc = -1;
    logic       prev_be, stable;

    always @(negedge clk) begin
        chk("grant_onehot", int'($countones(bif.grant) <= 1), 1);
        if (bif.grant != 4'd0) begin
            if (!in_svc) begin
                in_svc = 1'b1; svc_grant = bif.grant; svc_duty = bif.duty_cycle;
                len = 0; on_cnt = 0; rises = 0; hi_run = 0; lo_run = 0; pat_bad = 0;
                stable = 1'b1; prev_be = 1'b0;
                gap = (done_cyc >= 0) ? cyc - done_cyc : -1;
            end
            len++;
            if (bif.grant != svc_grant || bif.duty_cycle != svc_duty || !bif.busy) stable = 1'b0;
            if (bif.beep_enable) begin
                on_cnt++; hi_run++;
                if (!prev_be) begin
                    rises++;
                    if (lo_run != 0 && lo_run != OFF_CYC) pat_bad++;
                    lo_run = 0;
                end
            end else begin
                lo_run++;
                if (prev_be && hi_run != ON_CYC) pat_bad++;
                hi_run = 0;
            end
            prev_be = bif.beep_enable;
        end else begin
            if (bif.done != 4'd0) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=%b with empty scoreboard", bif.done);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_bit", int'(bif.done), int'(e.done));
                    chk("svc_duty", int'(svc_duty), int'(e.duty));
                    chk("beep_count", rises, e.beeps);
                    chk("svc_len", len, e.len);
                    chk("on_cycles", on_cnt, e.on);
                    if (lo_run != OFF_CYC) pat_bad++;
                    chk("pattern_runs_bad", pat_bad, 0);
                    chk("grant_duty_stable", int'(stable), 1);
                    chk("busy_at_done", int'(bif.busy), 0);
                    chk("duty_idle", int'(bif.duty_cycle), 0);
                    chk("be_at_done", int'(bif.beep_enable), 0);
                    if (e.gap >= 0) chk("idle_gap", gap, e.gap);
                end
            end
            in_svc = 1'b0;
        end
        if (bif.done != 4'd0) done_cyc = cyc;
    end

    task automatic wait_done(input logic [3:0] mask, input logic [3:0] drop);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while ((bif.done & mask) == 4'd0 && n < 400);
        if ((bif.done & mask) == 4'd0) begin
            total++; bad++;
            $display("FAIL wait_done_timeout: got done=%b expected mask %b", bif.done, mask);
        end
        bif.req = bif.req & ~drop;
    endtask

    task automatic wait_grant(input logic [3:0] mask);
        int n = 0;
        while ((bif.grant & mask) == 4'd0 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if ((bif.grant & mask) == 4'd0) begin
            total++; bad++;
            $display("FAIL wait_grant_timeout: got grant=%b expected mask %b", bif.grant, mask);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n = 1'b0;
        bif.req = 4'd0; bif.req_beeps = 16'd0; bif.req_duty = 16'd0;
        #3;
        chk("rst_be", int'(bif.beep_enable), 0);
        chk("rst_duty", int'(bif.duty_cycle), 0);
        chk("rst_grant", int'(bif.grant), 0);
        chk("rst_done", int'(bif.done), 0);
        chk("rst_busy", int'(bif.busy), 0);
        step(3);
        rst_n = 1'b1;
        step(3);
        chk("idle_busy", int'(bif.busy), 0);

        // Two beeps on requester 2.
        bif.req_beeps[11:8] = 4'd2; bif.req_duty[11:8] = 4'b1010;
        push(4'b0100, 4'b1010, 2, -1);
        bif.req = 4'b0100;
        step(1);
        chk("grant_latency", int'(bif.grant), 4'b0100);
        chk("be_latency", int'(bif.beep_enable), 1);
        wait_done(4'b0100, 4'b0100);
        step(3);

        // Beep count 0 plays once.
        bif.req_beeps[3:0] = 4'd0; bif.req_duty[3:0] = 4'b0011;
        push(4'b0001, 4'b0011, 1, -1);
        bif.req = 4'b0001;
        wait_done(4'b0001, 4'b0001);
        step(3);

        // Simultaneous requests 0 and 3.
        bif.req_beeps[3:0] = 4'd1; bif.req_duty[3:0] = 4'd5;
        bif.req_beeps[15:12] = 4'd1; bif.req_duty[15:12] = 4'd6;
`ifdef BEEP_SCHED_RR_EN
        push(4'b1000, 4'd6, 1, -1);
        push(4'b0001, 4'd5, 1, 1);
        bif.req = 4'b1001;
        wait_done(4'b1000, 4'b1000);
        wait_done(4'b0001, 4'b0001);
`else
        push(4'b0001, 4'd5, 1, -1);
        push(4'b1000, 4'd6, 1, 1);
        bif.req = 4'b1001;
        wait_done(4'b0001, 4'b0001);
        wait_done(4'b1000, 4'b1000);
`endif
        step(3);

        // No preemption: req[0] arrives during req[1] ON phase.
        bif.req_beeps[7:4] = 4'd1; bif.req_duty[7:4] = 4'd7;
        bif.req_beeps[3:0] = 4'd1; bif.req_duty[3:0] = 4'd2;
        push(4'b0010, 4'd7, 1, -1);
        push(4'b0001, 4'd2, 1, 1);
        bif.req = 4'b0010;
        wait_grant(4'b0010);
        step(4);
        bif.req = bif.req | 4'b0001;
        step(10);
        chk("no_preempt_grant", int'(bif.grant), 4'b0010);
        wait_done(4'b0010, 4'b0010);
        step(1);
        chk("next_grant", int'(bif.grant), 4'b0001);
        wait_done(4'b0001, 4'b0001);
        step(3);

        // Mid-service drop of req and change of duty/beeps.
        bif.req_beeps[7:4] = 4'd2; bif.req_duty[7:4] = 4'b1100;
        push(4'b0010, 4'b1100, 2, -1);
        bif.req = 4'b0010;
        wait_grant(4'b0010);
        step(3);
        bif.req = 4'd0; bif.req_duty = 16'hFFFF; bif.req_beeps = 16'hFFFF;
        wait_done(4'b0010, 4'b0010);
        bif.req_duty = 16'd0; bif.req_beeps = 16'd0;
        step(3);

        // Asynchronous reset mid-ON.
        bif.req_beeps[11:8] = 4'd3; bif.req_duty[11:8] = 4'd9;
        bif.req = 4'b0100;
        wait_grant(4'b0100);
        step(5);
        chk("pre_rst_be", int'(bif.beep_enable), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_be", int'(bif.beep_enable), 0);
        chk("arst_grant", int'(bif.grant), 0);
        chk("arst_busy", int'(bif.busy), 0);
        chk("arst_duty", int'(bif.duty_cycle), 0);
        bif.req = 4'd0;
        step(2);
        rst_n = 1'b1;
        step(30);
        chk("post_rst_busy", int'(bif.busy), 0);
        chk("post_rst_grant", int'(bif.grant), 0);

`ifdef BEEP_SCHED_RR_EN
        // Held 1111 from a fresh pointer rotates 0,1,2,3,0.
        bif.req_beeps = 16'h1111; bif.req_duty = 16'h4321;
        push(4'b0001, 4'd1, 1, -1);
        push(4'b0010, 4'd2, 1, 1);
        push(4'b0100, 4'd3, 1, 1);
        push(4'b1000, 4'd4, 1, 1);
        push(4'b0001, 4'd1, 1, 1);
        bif.req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(4'b1111, (k == 4) ? 4'b1111 : 4'b0000);
        step(3);
`endif

        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
